// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the multiplexed 7-segment driver.
package seg7_pkg;

    // Active-high glyphs, bit 6 = segment a ... bit 0 = segment g
    localparam logic [6:0] GLYPH_0     = 7'b1111110;
    localparam logic [6:0] GLYPH_1     = 7'b0110000;
    localparam logic [6:0] GLYPH_2     = 7'b1101101;
    localparam logic [6:0] GLYPH_3     = 7'b1111001;
    localparam logic [6:0] GLYPH_4     = 7'b0110011;
    localparam logic [6:0] GLYPH_5     = 7'b1011011;
    localparam logic [6:0] GLYPH_6     = 7'b1011111;
    localparam logic [6:0] GLYPH_7     = 7'b1110000;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1111011;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b0011111;
    localparam logic [6:0] GLYPH_C     = 7'b1001110;
    localparam logic [6:0] GLYPH_D     = 7'b0111101;
    localparam logic [6:0] GLYPH_E     = 7'b1001111;
    localparam logic [6:0] GLYPH_F     = 7'b1000111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Nibble to active-high glyph; in BCD mode 10..15 have no glyph
    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        if (!hex && nib > 4'd9) g = GLYPH_BLANK;
        return g;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph lookup for the currently scanned digit.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    input  logic       i_blank,
    output logic [6:0] o_glyph
);

    // Forced blank wins over the nibble decode
    always_comb o_glyph = i_blank ? GLYPH_BLANK : nibble_to_glyph(i_nibble, i_hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: frame-synchronous value update,
// dead time at each slot start, leading-zero blanking, decimal points, blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_load,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic [6:0]            o_segments,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit_en,
    output logic                  o_frame
);

    localparam int PW = cnt_w(PRESCALE);
    localparam int IW = cnt_w(N_DIGITS);
    localparam int FW = cnt_w(BLINK_FRAMES);
    localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_fcnt;
    logic                  r_phase;
    logic [4*N_DIGITS-1:0] r_shadow_val, r_active_val;
    logic [N_DIGITS-1:0]   r_shadow_dp, r_active_dp;
    logic                  r_pending;
    logic [6:0]            r_segments;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_digit_en;
    logic                  r_frame;

    logic                  w_slot_end, w_wrap;
    logic [3:0]            w_nib;
    logic                  w_dp_sel, w_lz_blank, w_run;
    logic [6:0]            w_glyph;
    logic [N_DIGITS-1:0]   w_onehot;

    assign w_slot_end = (r_presc == PW'(PRESCALE - 1));
    assign w_wrap     = w_slot_end && (r_idx == IW'(N_DIGITS - 1));
    assign w_onehot   = N_DIGITS'(1) << r_idx;

    // Slot prescaler and digit index; index wrap marks the frame boundary
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Blink phase toggles after every BLINK_FRAMES complete frames
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Shadow takes every load; active only refreshes at a frame boundary so a
    // frame never mixes two values. A load on the boundary stays pending.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_active_val <= r_shadow_val;
                r_active_dp  <= r_shadow_dp;
                r_pending    <= 1'b0;
            end
            if (i_load) begin
                r_shadow_val <= i_value;
                r_shadow_dp  <= i_dp;
                r_pending    <= 1'b1;
            end
        end
    end

    // Select the scanned nibble; a digit is a leading zero when it and all
    // higher digits are zero (digit 0 is never blanked)
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_lz_blank = 1'b0;
        w_run      = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_run = w_run && (r_active_val[4*k +: 4] == 4'h0);
            if (IW'(k) == r_idx) begin
                w_nib      = r_active_val[4*k +: 4];
                w_dp_sel   = r_active_dp[k];
                w_lz_blank = w_run && (k != 0);
            end
        end
    end

    seg7_glyph u_glyph (
        .i_nibble   (w_nib),
        .i_hex_mode (i_hex_mode),
        .i_blank    (w_lz_blank && i_blank_lz),
        .o_glyph    (w_glyph)
    );

    // Registered pins; digit enable held off on slot count 0 and in blink-off phase
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_segments <= SEG_OFF;
            r_dp       <= SEG_ACTIVE_LOW;
            r_digit_en <= DIG_OFF;
            r_frame    <= 1'b0;
        end else begin
            r_segments <= w_glyph ^ SEG_OFF;
            r_dp       <= w_dp_sel ^ SEG_ACTIVE_LOW;
            r_digit_en <= ((r_presc == '0) || (i_blink_en && r_phase)) ? DIG_OFF
                                                                       : (w_onehot ^ DIG_OFF);
            r_frame    <= w_wrap;
        end
    end

    assign o_segments = r_segments;
    assign o_dp       = r_dp;
    assign o_digit_en = r_digit_en;
    assign o_frame    = r_frame;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed multi-digit 7-segment display driver, the successor to the single-digit BCD decoder. It latches an N-digit BCD/hex value, scans one digit per time slot with anti-ghosting dead time, and applies leading-zero blanking, decimal points and blink. It sits between the datapath (counters, measurement results) and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (1..8).
PRESCALE, 1000, clocks per digit slot (>=2).
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).
SEG_ACTIVE_LOW, 1, 1 = segment/dp pins active-low, 0 = active-high.
DIG_ACTIVE_LOW, 1, 1 = digit-enable pins active-low, 0 = active-high.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_value  in  4*N_DIGITS  digit nibbles; [3:0] = digit 0 (rightmost)
i_load  in  1  one-cycle strobe: capture i_value/i_dp into shadow register
i_dp  in  N_DIGITS  decimal point per digit, captured with i_load
i_hex_mode  in  1  1 = nibbles 10..15 show A,b,C,d,E,F; 0 = BCD, 10..15 blank
i_blank_lz  in  1  1 = blank leading zero digits
i_blink_en  in  1  1 = whole display blinks
o_segments  out  7  segments, bit 6 = a ... bit 0 = g
o_dp  out  1  decimal point of active digit
o_digit_en  out  N_DIGITS  one-hot digit select (polarity per DIG_ACTIVE_LOW)
o_frame  out  1  one-cycle pulse at start of each scan frame

Behaviour:
- Reset (i_rst_n=0 at posedge): prescaler, digit index, frame/blink counters, shadow, active and pending registers cleared; o_segments/o_dp at "off" level, o_digit_en all inactive, o_frame=0. Takes effect mid-scan with no partial glyph.
- All outputs registered; glyph change visible one clock after the slot boundary.
- Prescaler counts 0..PRESCALE-1; on PRESCALE-1 wraps and digit index advances; index N_DIGITS-1 wraps to 0, which asserts o_frame for one cycle.
- Dead time: during prescaler count 0 of every slot, o_digit_en all inactive (segments already updated); counts 1..PRESCALE-1 drive the selected digit.
- Load: i_load captures into shadow and sets pending. Active register copied from shadow only at frame boundary (index wrap to 0), then pending cleared: no tearing. Multiple loads in one frame: last wins. Load coincident with boundary: new value goes to shadow, shown from next frame.
- Glyphs (active-high form, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, blank=0000000. SEG_ACTIVE_LOW inverts segments and dp.
- BCD mode, nibble 10..15: blank, dp still honoured.
- Leading-zero blank: digit k blanked iff every nibble from k up to N_DIGITS-1 is 0 and k>0; digit 0 always shown; dp unaffected.
- Blink: frame counter counts BLINK_FRAMES frames then toggles phase. Phase off with i_blink_en=1: all digits inactive. Deasserting i_blink_en shows immediately at next slot; counter keeps running.
- Input controls (hex_mode, blank_lz, blink_en) sampled live, not shadowed.

Decomposition:
- Package seg7_pkg: glyph constants per nibble, GLYPH_BLANK, function nibble-to-glyph (active-high), $clog2 width helpers.
- Sub-module seg7_glyph: combinational nibble + hex_mode + blank -> 7-bit active-high glyph; instantiated once on the muxed digit.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles mid-scan -> o_segments=7'h7F, o_dp=1, o_digit_en=4'hF (active-low), o_frame=0.
- Scan, PRESCALE=4, N_DIGITS=4, load 16'h1234 -> after the next frame boundary, digit 0 shows 4 (1001100 active-low), then 3, 2, 1 every 4 clocks; enable low for 3 clocks per slot, 1 dead clock; o_frame every 16 clocks.
- Tearing: load 16'h1111 then 16'h5678 in same frame -> no 1s displayed, 5678 from next frame only.
- LZ blank: i_value=16'h0007, i_blank_lz=1 -> digits 3..1 blank, digit 0 = 7; i_value=0 -> digit 0 shows 0.
- Hex vs BCD: nibble 4'hB -> hex_mode=1 shows b (0011111 active-high), hex_mode=0 blank.
- Blink: BLINK_FRAMES=2, i_blink_en=1 -> enables active 2 frames, all inactive 2 frames, repeating; deassert -> display resumes at next slot.
